// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core: one shared ALU, one unified stall-handshake memory port,
// and an IF/ID/EX/MEM/WB state sequence per instruction.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned NUM_REGS        = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [31:0] o_pc,
    output logic        o_halted,
    output logic        o_retire,
    output logic [31:0] o_retire_count
);
    localparam int unsigned RW = $clog2(NUM_REGS);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_retire_count;
    logic [31:0] r_regs [NUM_REGS];
    logic        r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic [31:0] w_imm, w_pc4, w_alu, w_alu_b, w_next_pc, w_wr_data;
    logic        w_is_r, w_r_ok, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j;
    logic        w_rs_bad, w_rt_bad, w_rd_bad, w_illegal, w_ex_done, w_retire, w_rf_we;
    logic        w_unused_shamt;

    assign w_op           = r_ir[31:26];
    assign w_rs           = r_ir[25:21];
    assign w_rt           = r_ir[20:16];
    assign w_rd           = r_ir[15:11];
    assign w_funct        = r_ir[5:0];
    assign w_unused_shamt = ^r_ir[10:6];
    assign w_imm          = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_pc4          = r_pc + 32'd4;

    assign w_is_r    = (w_op == 6'h00);
    assign w_is_addi = (w_op == 6'h08);
    assign w_is_lw   = (w_op == 6'h23);
    assign w_is_sw   = (w_op == 6'h2B);
    assign w_is_beq  = (w_op == 6'h04);
    assign w_is_j    = (w_op == 6'h02);
    assign w_r_ok    = (w_funct == 6'h20) || (w_funct == 6'h22) || (w_funct == 6'h24) ||
                       (w_funct == 6'h25) || (w_funct == 6'h2A);

    assign w_rs_bad  = ({27'b0, w_rs} >= NUM_REGS);
    assign w_rt_bad  = ({27'b0, w_rt} >= NUM_REGS);
    assign w_rd_bad  = ({27'b0, w_rd} >= NUM_REGS);
    // j uses no registers; every other legal opcode reads rs and rt, R-type also writes rd
    assign w_illegal = !((w_is_r && w_r_ok) || w_is_addi || w_is_lw || w_is_sw || w_is_beq ||
                         w_is_j) ||
                       (!w_is_j && (w_rs_bad || w_rt_bad)) || (w_is_r && w_rd_bad);

    assign w_alu_b = w_is_r ? r_b : w_imm;

    always_comb begin
        w_alu = r_a + w_alu_b;
        if (w_is_r) begin
            case (w_funct)
                6'h22:   w_alu = r_a - r_b;
                6'h24:   w_alu = r_a & r_b;
                6'h25:   w_alu = r_a | r_b;
                6'h2A:   w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    always_comb begin
        w_next_pc = w_pc4;
        if (!w_illegal && w_is_beq && (r_a == r_b)) begin
            w_next_pc = w_pc4 + {w_imm[29:0], 2'b00};
        end else if (!w_illegal && w_is_j) begin
            w_next_pc = {w_pc4[31:28], r_ir[25:0], 2'b00};
        end
    end

    assign w_ex_done = (r_state == S_EX) && (w_illegal || w_is_beq || w_is_j);
    assign w_retire  = w_ex_done || (r_state == S_WB) ||
                       ((r_state == S_MEM) && i_mem_ready && w_is_sw);

    assign w_dest    = w_is_r ? w_rd : w_rt;
    assign w_wr_data = w_is_lw ? r_mdr : r_alu;
    assign w_rf_we   = (r_state == S_WB) && (w_dest != 5'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
        end else if (w_rf_we) begin
            r_regs[w_dest[RW-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IF;
            r_pc           <= RESET_PC;
            r_ir           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_alu          <= '0;
            r_mdr          <= '0;
            r_retire_count <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
        end else begin
            case (r_state)
                S_IF: begin
                    // first cycle after reset only: launch the fetch
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                    end else if (i_mem_ready) begin
                        r_ir      <= i_mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_ID;
                    end
                end
                S_ID: begin
                    r_a     <= r_regs[w_rs[RW-1:0]];
                    r_b     <= r_regs[w_rt[RW-1:0]];
                    r_state <= (w_illegal && HALT_ON_ILLEGAL) ? S_HALT : S_EX;
                end
                S_EX: begin
                    r_alu <= w_alu;
                    if (w_ex_done) begin
                        r_pc           <= w_next_pc;
                        r_retire_count <= r_retire_count + 32'd1;
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= w_next_pc;
                        r_state        <= S_IF;
                    end else if (w_is_lw || w_is_sw) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_sw;
                        r_mem_addr  <= {w_alu[31:2], 2'b00};
                        r_mem_wdata <= r_b;
                        r_state     <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (w_is_sw) begin
                            r_pc           <= w_pc4;
                            r_retire_count <= r_retire_count + 32'd1;
                            r_mem_we       <= 1'b0;
                            r_mem_addr     <= w_pc4;
                            r_state        <= S_IF;
                        end else begin
                            r_mdr     <= i_mem_rdata;
                            r_mem_req <= 1'b0;
                            r_state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_pc           <= w_pc4;
                    r_retire_count <= r_retire_count + 32'd1;
                    r_mem_req      <= 1'b1;
                    r_mem_we       <= 1'b0;
                    r_mem_addr     <= w_pc4;
                    r_state        <= S_IF;
                end
                S_HALT: r_mem_req <= 1'b0;
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_HALT;
                end
            endcase
        end
    end

    assign o_mem_req      = r_mem_req;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_pc           = r_pc;
    assign o_halted       = (r_state == S_HALT);
    assign o_retire       = w_retire;
    assign o_retire_count = r_retire_count;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: wait-stated memory model, store scoreboard, and a second
// core instance built with NUM_REGS=8 and illegal-as-NOP.
module tb_mips_multicycle_core;
    logic clk, rst_n, rst8_n;
    int   total, bad;
    int   wait_cfg, wcnt1;

    logic        req1, we1, ready1, halted1, retire1;
    logic [31:0] addr1, wdata1, rdata1, pc1, cnt1;
    logic        req8, we8, ready8, halted8, retire8;
    logic [31:0] addr8, wdata8, rdata8, pc8, cnt8;

    logic [31:0] img1 [0:255];
    logic [31:0] mem1 [0:255];
    logic [31:0] img8 [0:255];
    logic [31:0] mem8 [0:255];
    logic [63:0] q1 [$];
    logic [63:0] q8 [$];
    logic [63:0] e1, e8;
    logic        hold_v;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata;
    logic        found;

    mips_multicycle_core u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_mem_req(req1), .o_mem_we(we1), .o_mem_addr(addr1),
        .o_mem_wdata(wdata1), .i_mem_rdata(rdata1), .i_mem_ready(ready1), .o_pc(pc1),
        .o_halted(halted1), .o_retire(retire1), .o_retire_count(cnt1)
    );

    mips_multicycle_core #(.NUM_REGS(8), .HALT_ON_ILLEGAL(1'b0)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst8_n), .o_mem_req(req8), .o_mem_we(we8), .o_mem_addr(addr8),
        .o_mem_wdata(wdata8), .i_mem_rdata(rdata8), .i_mem_ready(ready8), .o_pc(pc8),
        .o_halted(halted8), .o_retire(retire8), .o_retire_count(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ready1 = req1 && (wcnt1 >= wait_cfg);
    assign rdata1 = mem1[addr1[9:2]];
    assign ready8 = 1'b1;
    assign rdata8 = mem8[addr8[9:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            mem1  <= img1;
            wcnt1 <= 0;
        end else if (req1) begin
            if (ready1) begin
                wcnt1 <= 0;
                if (we1) mem1[addr1[9:2]] <= wdata1;
            end else begin
                wcnt1 <= wcnt1 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst8_n) mem8 <= img8;
        else if (req8 && we8) mem8[addr8[9:2]] <= wdata8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    // Store scoreboard and address/data stability through wait states.
    always @(negedge clk) begin
        if (req1) check("addr_align", {30'b0, addr1[1:0]}, 32'h0);
        if (req1 && hold_v) begin
            check("hold_addr", addr1, hold_addr);
            check("hold_we", {31'b0, we1}, {31'b0, hold_we});
            check("hold_wdata", wdata1, hold_wdata);
        end
        if (req1 && ready1 && we1) begin
            check("store_expected", (q1.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("store_addr", addr1, e1[63:32]);
                check("store_data", wdata1, e1[31:0]);
            end
        end
        if (req8 && ready8 && we8) begin
            check("store8_expected", (q8.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check("store8_addr", addr8, e8[63:32]);
                check("store8_data", wdata8, e8[31:0]);
            end
        end
        hold_v     <= req1 && !ready1;
        hold_addr  <= addr1;
        hold_we    <= we1;
        hold_wdata <= wdata1;
    end

    task automatic load_prog1();
        for (int i = 0; i < 256; i++) img1[i] = 32'h0;
        img1[8'h00 >> 2] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img1[8'h04 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        img1[8'h08 >> 2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        img1[8'h0C >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
        img1[8'h10 >> 2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        img1[8'h14 >> 2] = enc_j(32'h80);
        img1[8'h80 >> 2] = enc_r(5'd4, 5'd1, 5'd5, 6'h22);
        img1[8'h84 >> 2] = enc_r(5'd1, 5'd5, 5'd6, 6'h2A);
        img1[8'h88 >> 2] = enc_r(5'd3, 5'd2, 5'd7, 6'h24);
        img1[8'h8C >> 2] = enc_r(5'd3, 5'd1, 5'd8, 6'h25);
        img1[8'h90 >> 2] = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
        img1[8'h94 >> 2] = enc_r(5'd9, 5'd1, 5'd10, 6'h2A);
        img1[8'h98 >> 2] = enc_r(5'd1, 5'd9, 5'd11, 6'h2A);
        for (int i = 0; i < 8; i++) begin
            img1[(32'h9C >> 2) + i] = enc_i(6'h2B, 5'd0, 5'(4 + i), 16'(32'h180 + 4 * i));
        end
        img1[8'hBC >> 2] = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
        img1[8'hC0 >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h01A0);
        img1[8'hC4 >> 2] = enc_j(32'h100);
        img1[32'h100 >> 2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    endtask

    task automatic expect_prog1();
        q1.delete();
        q1.push_back({32'h40, 32'd12});
        q1.push_back({32'h180, 32'd12});
        q1.push_back({32'h184, 32'd7});
        q1.push_back({32'h188, 32'd1});
        q1.push_back({32'h18C, 32'd4});
        q1.push_back({32'h190, 32'd13});
        q1.push_back({32'h194, 32'hFFFF_FFFD});
        q1.push_back({32'h198, 32'd1});
        q1.push_back({32'h19C, 32'd0});
        q1.push_back({32'h1A0, 32'd5});
    endtask

    initial begin
        total = 0; bad = 0; wait_cfg = 0;
        rst_n = 1'b0; rst8_n = 1'b0;
        load_prog1();
        expect_prog1();
        for (int i = 0; i < 256; i++) img8[i] = 32'h0;
        img8[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        img8[1] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0040);
        img8[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
        img8[3] = 32'hFC00_0000;
        img8[4] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        img8[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0044);
        img8[6] = enc_j(32'h18);
        q8.push_back({32'h40, 32'd0});
        q8.push_back({32'h44, 32'd3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, req1}, 32'h0);
        check("rst_we", {31'b0, we1}, 32'h0);
        check("rst_addr", addr1, 32'h0);
        check("rst_wdata", wdata1, 32'h0);
        check("rst_pc", pc1, 32'h0);
        check("rst_halted", {31'b0, halted1}, 32'h0);
        check("rst_retire", {31'b0, retire1}, 32'h0);
        check("rst_count", cnt1, 32'h0);

        rst_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("first_req", {31'b0, req1}, 32'h1);
        check("first_addr", addr1, 32'h0);

        repeat (12) @(posedge clk);
        @(negedge clk);
        check("cnt_after_12", cnt1, 32'd3);
        check("pc_after_12", pc1, 32'h0C);
        check("cnt8_after_12", cnt8, 32'd3);
        check("pc8_after_12", pc8, 32'h0C);

        wait_cfg = 2;
        for (int i = 0; i < 1000 && pc1 != 32'h100; i++) @(negedge clk);
        check("reach_loop_pc", pc1, 32'h100);
        check("reach_loop_cnt", cnt1, 32'd24);
        check("stores_drained", 32'(q1.size()), 32'd0);

        wait_cfg = 0;
        for (int k = 1; k <= 3; k++) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("beq_retire", {31'b0, retire1}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            check("beq_pc", pc1, 32'h100);
            check("beq_cnt", cnt1, 32'(24 + k));
        end
        check("dut8_pc", pc8, 32'h18);
        check("dut8_halted", {31'b0, halted8}, 32'h0);
        check("dut8_stores", 32'(q8.size()), 32'd0);

        // Rerun with wait states and reset during the waited lw data access.
        wait_cfg = 2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_prog1();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = req1 && !we1 && (addr1 == 32'h40) && !ready1;
        end
        check("lw_wait_seen", {31'b0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", {31'b0, req1}, 32'h0);
        check("midrst_pc", pc1, 32'h0);
        check("midrst_count", cnt1, 32'h0);
        check("midrst_halted", {31'b0, halted1}, 32'h0);
        q1.delete();

        for (int i = 0; i < 256; i++) img1[i] = 32'h0;
        img1[0] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0060);
        img1[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0064);
        img1[2] = 32'hFC00_0000;
        q1.push_back({32'h60, 32'd0});
        q1.push_back({32'h64, 32'd0});
        wait_cfg = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("refetch_req", {31'b0, req1}, 32'h1);
        check("refetch_addr", addr1, 32'h0);

        for (int i = 0; i < 100 && !halted1; i++) @(negedge clk);
        check("halted", {31'b0, halted1}, 32'h1);
        check("halt_pc", pc1, 32'h8);
        check("halt_count", cnt1, 32'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_no_req", {31'b0, req1}, 32'h0);
            check("halt_sticky", {31'b0, halted1}, 32'h1);
        end
        check("zero_reg_stores", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle successor to the single-cycle MIPS32 datapath: one shared ALU, one unified memory port, and a five-state FSM sequence each instruction (IF, ID, EX, MEM, WB). The memory port uses a stall handshake, so the core runs against slow or wait-stated memory. Register file depth and illegal-opcode policy are parametrised. The core is the CPU top for the next SoC integration: it connects to the memory subsystem only through the port below.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- NUM_REGS, 32, register count; power of two, 8..32. Index width RW = log2(NUM_REGS).
- HALT_ON_ILLEGAL, 1, 1: illegal instruction enters HALT; 0: executes as NOP and retires.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  out  1  transfer request.
- mem_we  out  1  1 = write (sw); 0 = read.
- mem_addr  out  32  byte address; bits [1:0] always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle where mem_req && mem_ready.
- mem_ready  in  1  completes the current transfer.
- pc  out  32  address of the instruction in flight.
- halted  out  1  core is in HALT.
- retire  out  1  one-cycle pulse per completed instruction.
- retire_count  out  32  retired instruction count; wraps at 2^32.

## Operation
- Supported instructions:
  - R-type (funct): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- Illegal instruction: any other opcode or funct, or any used register index >= NUM_REGS.
- Register 0 reads as 0; writes to it are discarded. All other registers reset to 0.
- IF:
  - Drive mem_req=1, mem_we=0, mem_addr=pc.
  - Hold until mem_ready, then latch IR and go to ID.
- ID: read rs and rt into A and B; compute sext(imm). Go to EX, or to HALT if illegal and HALT_ON_ILLEGAL=1.
- EX:
  - ALU operation, or address = A + sext(imm).
  - beq: if A==B, pc <= pc+4+(sext(imm)<<2); else pc+4. Retire, go to IF.
  - j: pc <= {pc_plus4[31:28], IR[25:0], 2'b00}. Retire, go to IF.
  - Illegal with HALT_ON_ILLEGAL=0: pc+4, retire, go to IF.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - Drive mem_req=1, mem_addr = ALU result with bits [1:0] forced to 0, mem_we = (sw), mem_wdata = B.
  - Hold until mem_ready.
  - sw: pc+4, retire, go to IF. lw: latch MDR, go to WB.
- WB: write rd (R-type) or rt (addi, lw). pc+4, retire, go to IF.
- HALT: absorbing. Only rst_n exits it. mem_req=0, halted=1.
- Arithmetic: 32-bit modulo; overflow ignored. PC increments modulo 2^32, so 0xFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=IF.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - halted=0, retire=0, retire_count=0.
  - All registers 0.
- mem_req asserts the first clk edge after rst_n deasserts.
- While mem_req=1, the core holds mem_addr, mem_we and mem_wdata stable until the mem_ready cycle.
- A transfer completes in any cycle where mem_req && mem_ready. mem_ready while mem_req=0 is ignored.
- Minimum cycles per instruction (mem_ready tied high):
  - beq, j, illegal NOP: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- Each memory wait cycle adds one cycle to the instruction.
- retire is asserted in the final cycle of the instruction. retire_count increments on the same edge that updates pc.
- rst_n low mid-instruction: all state returns to reset immediately. Any pending transfer is abandoned; mem_req drops asynchronously.

## Test plan
- Reset, mem_ready=1, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, retire_count=3 after 12 cycles.
- sw r3,0x40(r0) then lw r4,0x40(r0), with memory inserting 2 wait cycles per transfer -> write at addr 0x40 with data 12, r4=12, address and data stable through the waits.
- beq r1,r1,-1 at pc 0x100 -> pc returns to 0x100 every 3 cycles; beq with r1≠r2 -> pc=0x104.
- Opcode 0x3F: HALT_ON_ILLEGAL=1 -> halted=1, mem_req=0 forever; HALT_ON_ILLEGAL=0 -> pc+4, retire pulse.
- NUM_REGS=8, instruction using r9 -> treated as illegal. addi r0,r0,9 -> r0 still reads 0.
- rst_n pulsed low during a waited lw -> pc=RESET_PC, retire_count=0, registers 0, fetch restarts at RESET_PC.
